xalu_word_seq: RTL and testbench

Nibble-serial sequencer that drives one 4-bit `tt_um_kb2ghz_xalu` slice to execute a full NIBBLES×4-bit operation. It is the initiator side of the slice interface: it latches a word-wide request, presents one nibble per cycle on the slice's operand, function and carry inputs, and chains the slice's carry outputs back into the next nibble. It assembles the result word and word-level status flags, then pulses `done`.

---
 rtl/xalu_pkg.sv | 19 +
 rtl/tt_um_kb2ghz_xalu.sv | 50 +++++
 rtl/xalu_word_seq.sv | 208 ++++++++++++++++++++
 tb/tb_xalu_word_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/xalu_pkg.sv
// rtl/xalu_pkg.sv - shared op codes and sequencer states for the xalu word sequencer
package xalu_pkg;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_AND   = 3'd1;
    localparam logic [2:0] OP_OR    = 3'd2;
    localparam logic [2:0] OP_XOR   = 3'd3;
    localparam logic [2:0] OP_PASSA = 3'd4;
    localparam logic [2:0] OP_PASSB = 3'd5;
    localparam logic [2:0] OP_SHR   = 3'd6;
    localparam logic [2:0] OP_SHL   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/tt_um_kb2ghz_xalu.sv
// rtl/tt_um_kb2ghz_xalu.sv - combinational 4-bit xalu slice driven by the word sequencer
module tt_um_kb2ghz_xalu
    import xalu_pkg::*;
(
    input  logic [2:0] f_i,
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       com_i,
    input  logic       ci_right_i,
    input  logic       ci_left_i,
    output logic [3:0] d_o,
    output logic       co_left_o,
    output logic       co_right_o,
    output logic       zero_o,
    output logic       neg_zero_o,
    output logic       equ_o
);

    logic [3:0] raw;

    always_comb begin
        raw        = 4'd0;
        co_left_o  = 1'b0;
        co_right_o = 1'b0;
        case (f_i)
            OP_ADD:   {co_left_o, raw} = {1'b0, a_i} + {1'b0, b_i} + {4'd0, ci_right_i};
            OP_AND:   raw = a_i & b_i;
            OP_OR:    raw = a_i | b_i;
            OP_XOR:   raw = a_i ^ b_i;
            OP_PASSA: raw = a_i;
            OP_PASSB: raw = b_i;
            OP_SHR: begin
                raw        = {ci_left_i, a_i[3:1]};
                co_right_o = a_i[0];
            end
            OP_SHL: begin
                raw       = {a_i[2:0], ci_right_i};
                co_left_o = a_i[3];
            end
            default: raw = 4'd0;
        endcase
    end

    // Complement applies to the data only; carries and compare see the true values.
    assign d_o        = com_i ? ~raw : raw;
    assign zero_o     = (d_o == 4'd0);
    assign neg_zero_o = &d_o;
    assign equ_o      = (a_i == b_i);

endmodule

// File: rtl/xalu_word_seq.sv
// rtl/xalu_word_seq.sv - nibble-serial sequencer running a word-wide op through one 4-bit xalu slice
module xalu_word_seq
    import xalu_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [2:0]             op,
    input  logic                   com,
    input  logic [4*NIBBLES-1:0]   a_word,
    input  logic [4*NIBBLES-1:0]   b_word,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   zero,
    output logic                   neg_zero,
    output logic                   equ,
    output logic [2:0]             sl_f,
    output logic [3:0]             sl_a,
    output logic [3:0]             sl_b,
    output logic                   sl_com,
    output logic                   sl_ci_right,
    output logic                   sl_ci_left,
    input  logic [3:0]             sl_d,
    input  logic                   sl_co_left,
    input  logic                   sl_co_right,
    input  logic                   sl_zero,
    input  logic                   sl_neg_zero,
    input  logic                   sl_equ
);

    localparam int W  = 4 * NIBBLES;
    localparam int KW = $clog2(NIBBLES);
    localparam logic [KW-1:0] LAST = KW'(NIBBLES - 1);

    seq_state_e    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [2:0]    op_q, op_d;
    logic          com_q, com_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic [W-1:0]  stage_q, stage_d;
    logic          zacc_q, zacc_d, nacc_q, nacc_d, eacc_q, eacc_d;
    logic [W-1:0]  result_q, result_d;
    logic          cout_q, cout_d, zero_q, zero_d, nz_q, nz_d, equ_q, equ_d;
    logic [2:0]    sl_f_q, sl_f_d;
    logic [3:0]    sl_a_q, sl_a_d, sl_b_q, sl_b_d;
    logic          sl_com_q, sl_com_d, sl_cir_q, sl_cir_d, sl_cil_q, sl_cil_d;

    logic          run_shr, start_shr;
    logic [KW-1:0] cur_idx, nxt_k, nxt_idx, first_idx;
    logic [W-1:0]  stage_w;

    function automatic logic [3:0] nib_sel(input logic [W-1:0] w, input logic [KW-1:0] i);
        nib_sel = 4'd0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (i == KW'(n)) nib_sel = w[n*4 +: 4];
        end
    endfunction

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        op_d     = op_q;
        com_d    = com_q;
        a_d      = a_q;
        b_d      = b_q;
        stage_d  = stage_q;
        zacc_d   = zacc_q;
        nacc_d   = nacc_q;
        eacc_d   = eacc_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        nz_d     = nz_q;
        equ_d    = equ_q;
        sl_f_d   = 3'd0;
        sl_a_d   = 4'd0;
        sl_b_d   = 4'd0;
        sl_com_d = 1'b0;
        sl_cir_d = 1'b0;
        sl_cil_d = 1'b0;

        // SHR walks the word MSB nibble first so the shift-in travels downward.
        run_shr   = (op_q == OP_SHR);
        start_shr = (op == OP_SHR);
        cur_idx   = run_shr ? LAST - k_q : k_q;
        nxt_k     = k_q + 1'b1;
        nxt_idx   = run_shr ? LAST - nxt_k : nxt_k;
        first_idx = start_shr ? LAST : '0;

        stage_w = stage_q;
        for (int n = 0; n < NIBBLES; n++) begin
            if (cur_idx == KW'(n)) stage_w[n*4 +: 4] = sl_d;
        end

        case (state_q)
            RUN: begin
                stage_d = stage_w;
                zacc_d  = zacc_q & sl_zero;
                nacc_d  = nacc_q & sl_neg_zero;
                eacc_d  = eacc_q & sl_equ;
                if (k_q == LAST) begin
                    state_d  = DONE;
                    result_d = stage_w;
                    zero_d   = zacc_q & sl_zero;
                    nz_d     = nacc_q & sl_neg_zero;
                    equ_d    = eacc_q & sl_equ;
                    cout_d   = run_shr ? sl_co_right : sl_co_left;
                end else begin
                    k_d      = nxt_k;
                    sl_f_d   = op_q;
                    sl_com_d = com_q;
                    sl_a_d   = nib_sel(a_q, nxt_idx);
                    sl_b_d   = nib_sel(b_q, nxt_idx);
                    sl_cil_d = run_shr & sl_co_right;
                    sl_cir_d = ~run_shr & sl_co_left;
                end
            end
            default: begin
                state_d = IDLE;
                if (start) begin
                    state_d  = RUN;
                    op_d     = op;
                    com_d    = com;
                    a_d      = a_word;
                    b_d      = b_word;
                    k_d      = '0;
                    zacc_d   = 1'b1;
                    nacc_d   = 1'b1;
                    eacc_d   = 1'b1;
                    sl_f_d   = op;
                    sl_com_d = com;
                    sl_a_d   = nib_sel(a_word, first_idx);
                    sl_b_d   = nib_sel(b_word, first_idx);
                    sl_cil_d = start_shr & cin;
                    sl_cir_d = ~start_shr & cin;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            op_q     <= 3'd0;
            com_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            stage_q  <= '0;
            zacc_q   <= 1'b0;
            nacc_q   <= 1'b0;
            eacc_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            nz_q     <= 1'b0;
            equ_q    <= 1'b0;
            sl_f_q   <= 3'd0;
            sl_a_q   <= 4'd0;
            sl_b_q   <= 4'd0;
            sl_com_q <= 1'b0;
            sl_cir_q <= 1'b0;
            sl_cil_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            op_q     <= op_d;
            com_q    <= com_d;
            a_q      <= a_d;
            b_q      <= b_d;
            stage_q  <= stage_d;
            zacc_q   <= zacc_d;
            nacc_q   <= nacc_d;
            eacc_q   <= eacc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            nz_q     <= nz_d;
            equ_q    <= equ_d;
            sl_f_q   <= sl_f_d;
            sl_a_q   <= sl_a_d;
            sl_b_q   <= sl_b_d;
            sl_com_q <= sl_com_d;
            sl_cir_q <= sl_cir_d;
            sl_cil_q <= sl_cil_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign result      = result_q;
    assign cout        = cout_q;
    assign zero        = zero_q;
    assign neg_zero    = nz_q;
    assign equ         = equ_q;
    assign sl_f        = sl_f_q;
    assign sl_a        = sl_a_q;
    assign sl_b        = sl_b_q;
    assign sl_com      = sl_com_q;
    assign sl_ci_right = sl_cir_q;
    assign sl_ci_left  = sl_cil_q;

endmodule

// File: tb/tb_xalu_word_seq.sv
// tb/tb_xalu_word_seq.sv - self-checking bench for xalu_word_seq paired with the xalu slice
module tb_xalu_word_seq;
    import xalu_pkg::*;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst, start, com, cin;
    logic [2:0]   op;
    logic [W-1:0] a_word, b_word;
    logic         busy, done, cout, zero, neg_zero, equ;
    logic [W-1:0] result;
    logic [2:0]   sl_f;
    logic [3:0]   sl_a, sl_b, sl_d;
    logic         sl_com, sl_ci_right, sl_ci_left;
    logic         sl_co_left, sl_co_right, sl_zero, sl_neg_zero, sl_equ;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    xalu_word_seq #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .com(com),
        .a_word(a_word), .b_word(b_word), .cin(cin),
        .busy(busy), .done(done), .result(result), .cout(cout),
        .zero(zero), .neg_zero(neg_zero), .equ(equ),
        .sl_f(sl_f), .sl_a(sl_a), .sl_b(sl_b), .sl_com(sl_com),
        .sl_ci_right(sl_ci_right), .sl_ci_left(sl_ci_left),
        .sl_d(sl_d), .sl_co_left(sl_co_left), .sl_co_right(sl_co_right),
        .sl_zero(sl_zero), .sl_neg_zero(sl_neg_zero), .sl_equ(sl_equ)
    );

    tt_um_kb2ghz_xalu u_slice (
        .f_i(sl_f), .a_i(sl_a), .b_i(sl_b), .com_i(sl_com),
        .ci_right_i(sl_ci_right), .ci_left_i(sl_ci_left),
        .d_o(sl_d), .co_left_o(sl_co_left), .co_right_o(sl_co_right),
        .zero_o(sl_zero), .neg_zero_o(sl_neg_zero), .equ_o(sl_equ)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Whole-word reference: plain arithmetic on the full operands.
    task automatic model(input logic [2:0] o, input logic c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, output logic [W-1:0] r, output logic co,
                         output logic z, output logic nz, output logic eq);
        logic [W:0] s;
        co = 1'b0;
        r  = '0;
        case (o)
            OP_ADD: begin
                s  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
                r  = s[W-1:0];
                co = s[W];
            end
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_PASSA: r = a;
            OP_PASSB: r = b;
            OP_SHR: begin
                r  = {ci, a[W-1:1]};
                co = a[0];
            end
            default: begin
                r  = {a[W-2:0], ci};
                co = a[W-1];
            end
        endcase
        if (c) r = ~r;
        z  = (r == '0);
        nz = (r == '1);
        eq = (a == b);
    endtask

    // Carry entering bit 4k of a+b+ci.
    function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input int k);
        logic [W:0] m, part;
        m    = ({{W{1'b0}}, 1'b1} << (4 * k)) - 1'b1;
        part = ({1'b0, a} & m) + ({1'b0, b} & m) + {{W{1'b0}}, ci};
        part = part >> (4 * k);
        return part[0];
    endfunction

    // Called at a negedge in IDLE/DONE; returns at the negedge of the DONE cycle.
    task automatic do_op(input logic [2:0] o, input logic c, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        logic [W-1:0] er;
        logic eco, ez, enz, eeq, ecir, ecil;
        int idx;
        model(o, c, a, b, ci, er, eco, ez, enz, eeq);
        op = o; com = c; a_word = a; b_word = b; cin = ci; start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            if (k == 0) begin
                start = 1'b0;
                a_word = W'($urandom); b_word = W'($urandom);
                op = 3'($urandom); com = 1'($urandom); cin = 1'($urandom);
            end
            chk($sformatf("busy op%0d k%0d", o, k), busy, 1);
            chk($sformatf("done_in_run op%0d k%0d", o, k), done, 0);
            chk($sformatf("sl_f_com op%0d k%0d", o, k), {sl_com, sl_f}, {c, o});
            idx = (o == OP_SHR) ? N - 1 - k : k;
            chk($sformatf("sl_a op%0d k%0d", o, k), sl_a, a[idx*4 +: 4]);
            chk($sformatf("sl_b op%0d k%0d", o, k), sl_b, b[idx*4 +: 4]);
            ecir = 1'b0;
            ecil = 1'b0;
            if (o == OP_SHR) begin
                if (k == 0) ecil = ci; else ecil = a[W - 4*k];
            end else if (o == OP_ADD) begin
                ecir = carry_into(a, b, ci, k);
            end else if (o == OP_SHL) begin
                if (k == 0) ecir = ci; else ecir = a[4*k - 1];
            end else begin
                if (k == 0) ecir = ci;
            end
            chk($sformatf("sl_ci op%0d k%0d", o, k), {sl_ci_left, sl_ci_right}, {ecil, ecir});
            @(negedge clk);
        end
        chk($sformatf("done op%0d", o), {busy, done}, 2'b01);
        chk($sformatf("result op%0d a%0h b%0h", o, a, b), result, er);
        chk($sformatf("flags op%0d a%0h b%0h", o, a, b), {cout, zero, neg_zero, equ}, {eco, ez, enz, eeq});
        chk($sformatf("sl_idle op%0d", o), {sl_f, sl_a, sl_b, sl_com, sl_ci_right, sl_ci_left}, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'd0; com = 1'b0; cin = 1'b0;
        a_word = '0; b_word = '0;
        repeat (2) @(negedge clk);
        chk("reset_ctl", {busy, done, cout, zero, neg_zero, equ}, 0);
        chk("reset_result", result, 0);
        chk("reset_sl", {sl_f, sl_a, sl_b, sl_com, sl_ci_right, sl_ci_left}, 0);
        rst = 1'b0;
        @(negedge clk);

        do_op(OP_ADD, 1'b0, 16'h00FF, 16'h0001, 1'b0);
        do_op(OP_ADD, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
        do_op(OP_SHR, 1'b0, 16'h8001, 16'h0000, 1'b1);
        do_op(OP_SHL, 1'b0, 16'h8001, 16'h0000, 1'b0);
        do_op(OP_XOR, 1'b1, 16'h1234, 16'h1234, 1'b0);
        @(negedge clk);
        chk("idle_after_done", {busy, done}, 0);

        // Restart attempt mid-run is ignored, then reset aborts the op.
        do_op(OP_ADD, 1'b0, 16'h00FF, 16'h0001, 1'b0);
        op = OP_ADD; com = 1'b0; cin = 1'b0; a_word = 16'h1234; b_word = 16'h1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort_s0_busy", busy, 1);
        @(negedge clk);
        start = 1'b1; a_word = 16'hFFFF;
        @(negedge clk);
        chk("abort_s2_busy", busy, 1);
        chk("abort_s2_sl_a", sl_a, 4'h2);
        start = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ctl", {busy, done}, 0);
        chk("abort_result", result, 0);
        chk("abort_sl", {sl_f, sl_a, sl_b, sl_com, sl_ci_right, sl_ci_left}, 0);
        do_op(OP_ADD, 1'b0, 16'h1234, 16'h1111, 1'b1);

        // Reset wins over a simultaneous start.
        rst = 1'b1; start = 1'b1; op = OP_ADD;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_start_busy", {busy, done}, 0);
        @(negedge clk);
        chk("rst_start_idle", {busy, done}, 0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                chk("rand_gap_idle", {busy, done}, 0);
            end
            do_op(3'($urandom), 1'($urandom), W'($urandom), W'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
